dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase-accumulator/sine-LUT datapath. It drives the DDS `phase_inc_i` input. On command it steps the phase increment from a start value to a stop value in fixed increments, holding each value for a programmable number of clock cycles. It generates the linear chirps and stepped-tone stimulus used to characterise the FIR filter.

## Interface
- `PHASE_WIDTH`, default 16: width of phase increment; must match the DDS instance.
- `DWELL_WIDTH`, default 16: width of the dwell (cycles-per-step) count.

- `clk_i` input 1: single clock for the block and the DDS.
- `arstn_i` input 1: asynchronous, active-low reset.
- `start_i` input 1: start pulse; sampled only in IDLE.
- `abort_i` input 1: stops the sweep immediately; no `done_o`.
- `repeat_i` input 1: 0 runs a single sweep; 1 restarts automatically from the start value.
- `f_start_i` input PHASE_WIDTH: first phase increment.
- `f_stop_i` input PHASE_WIDTH: last phase increment. It may be below `f_start_i`, which gives a down-sweep.
- `f_step_i` input PHASE_WIDTH: unsigned step magnitude.
- `dwell_i` input DWELL_WIDTH: cycles each value is held; 0 is treated as 1.
- `phase_inc_o` output PHASE_WIDTH: to DDS `phase_inc_i`.
- `busy_o` output 1: high while a sweep is active.
- `step_o` output 1: one-cycle pulse each time `phase_inc_o` is loaded with a sweep value.
- `done_o` output 1: one-cycle pulse at the end of a single sweep, or at each wrap in repeat mode.

## Operation
- States: IDLE, SWEEP.
- Reset (async, any time including mid-sweep): state IDLE, `phase_inc_o`=0, `busy_o`=0, `step_o`=0, `done_o`=0, dwell counter=0.
- IDLE, `start_i`=1 and `abort_i`=0:
  - Latch `f_start_i`, `f_stop_i`, `f_step_i`, `dwell_i`, `repeat_i` into shadow registers.
  - Set `dir` = (`f_stop_i` < `f_start_i`) ? down : up.
  - Load `phase_inc_o` = `f_start_i` and dwell counter = max(`dwell_i`,1)-1.
  - Pulse `step_o` and go to SWEEP.
- Inputs are ignored except at start. Changing them mid-sweep has no effect.
- SWEEP, dwell counter ≠ 0: decrement; `phase_inc_o` holds.
- SWEEP, dwell counter = 0 and `phase_inc_o` ≠ latched stop: compute the next value, reload the counter, and pulse `step_o`.
  - Up: next = cur + step, computed PHASE_WIDTH+1 bits wide. If next ≥ stop (including carry-out), next = stop.
  - Down: next = cur − step. If borrow or next ≤ stop, next = stop.
  - `f_step`=0: next = stop. The sweep never stalls.
- SWEEP, dwell counter = 0 and `phase_inc_o` = stop, i.e. the last value has completed its dwell:
  - Pulse `done_o`.
  - Repeat=0: go to IDLE; `phase_inc_o`=0, `busy_o`=0.
  - Repeat=1: reload latched start and dwell, pulse `step_o`, stay in SWEEP.
- `f_start` = `f_stop`: the sweep is a single point held for one dwell, then done.
- `abort_i`=1 in any state: go to IDLE next edge with `phase_inc_o`=0 and `busy_o`=0. No `done_o` and no `step_o`.
- `abort_i` has priority over `start_i` and over a simultaneous end-of-sweep.
- `start_i` while in SWEEP is ignored.
- Point count N = ceil(|stop−start| / step) + 1, with step 0 giving N=2 (1 if start = stop).

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `start_i` sampled at edge k: `phase_inc_o`=f_start, `busy_o`=1 and `step_o`=1 are visible after edge k.
- Each value is held for exactly D = max(dwell,1) cycles. Successive `step_o` pulses are D cycles apart.
- `done_o` pulses in the cycle following the last value's final dwell cycle, i.e. N·D cycles after the first `step_o`. In that same cycle `phase_inc_o`=0 and `busy_o`=0 (single mode).
- Repeat mode: `done_o` and `step_o` pulse together. `phase_inc_o` returns to start in that same cycle, with no gap cycle.
- The earliest accepted restart is the cycle in which `busy_o` is first low.
- `abort_i` at edge k: outputs are idle after edge k.

## Test plan
- Up-sweep, single: start=0x0100, stop=0x0400, step=0x0100, dwell=3 -> `phase_inc_o` 0x100,0x200,0x300,0x400, each for 3 cycles; 4 `step_o` pulses; `done_o` 12 cycles after the first `step_o`, then `phase_inc_o`=0.
- Clamp and down-sweep:
  - start=0x0100, stop=0x0400, step=0x0180, dwell=1 -> 0x100,0x280,0x400.
  - start=0x0400, stop=0x0100, step=0x0180 -> 0x400,0x280,0x100.
- Overflow edge: start=0xFF00, stop=0xFFFF, step=0x0200 -> 0xFF00, then 0xFFFF (no wrap to 0x0100); done after 2·D cycles.
- Degenerate inputs:
  - dwell=0 behaves as dwell=1.
  - step=0 gives start then stop.
  - start=stop=0x1234, dwell=5 -> one `step_o`, `done_o` after 5 cycles.
- Repeat mode: 0x10→0x30, step 0x10, dwell=2 -> the pattern 0x10,0x20,0x30 repeats with no gap. `done_o` and `step_o` coincide at each wrap; `start_i` pulses mid-sweep have no effect.
- Abort and reset:
  - `abort_i` mid-dwell -> `phase_inc_o`=0 and `busy_o`=0 next cycle, no `done_o`.
  - `abort_i` together with `start_i` in IDLE -> stays IDLE.
  - `arstn_i` low mid-sweep -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Control and status bundle between a sweep master and the DDS sweep sequencer.
interface dds_sweep_ctrl_if #(
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic                   start_i;
  logic                   abort_i;
  logic                   repeat_i;
  logic [PHASE_WIDTH-1:0] f_start_i;
  logic [PHASE_WIDTH-1:0] f_stop_i;
  logic [PHASE_WIDTH-1:0] f_step_i;
  logic [DWELL_WIDTH-1:0] dwell_i;
  logic [PHASE_WIDTH-1:0] phase_inc_o;
  logic                   busy_o;
  logic                   step_o;
  logic                   done_o;

  modport master (
    output start_i, abort_i, repeat_i, f_start_i, f_stop_i, f_step_i, dwell_i,
    input  phase_inc_o, busy_o, step_o, done_o
  );

  modport slave (
    input  start_i, abort_i, repeat_i, f_start_i, f_stop_i, f_step_i, dwell_i,
    output phase_inc_o, busy_o, step_o, done_o
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS phase increment from start to stop,
// holding each value for a programmable dwell, optionally repeating.
module dds_sweep_ctrl #(
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  dds_sweep_ctrl_if.slave   bus
);
  localparam int unsigned PW = PHASE_WIDTH;
  localparam int unsigned DW = DWELL_WIDTH;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] start_q, start_d;
  logic [PW-1:0] stop_q, stop_d;
  logic [PW-1:0] inc_q, inc_d;
  logic [DW-1:0] reload_q, reload_d;
  logic          rpt_q, rpt_d;
  logic          down_q, down_d;
  logic          busy_q, busy_d;
  logic          step_q, step_d;
  logic          done_q, done_d;

  logic [PW:0]   sum_c;
  logic [PW:0]   diff_c;
  logic [PW-1:0] next_c;
  logic [DW-1:0] dwell_rl_c;

  assign bus.phase_inc_o = cur_q;
  assign bus.busy_o      = busy_q;
  assign bus.step_o      = step_q;
  assign bus.done_o      = done_q;

  // Dwell of 0 behaves as 1; the counter holds cycles remaining after the current one.
  assign dwell_rl_c = (bus.dwell_i == '0) ? '0 : bus.dwell_i - DW'(1);

  // Next sweep point, clamped to stop on overshoot, carry-out or borrow.
  always_comb begin
    sum_c  = {1'b0, cur_q} + {1'b0, inc_q};
    diff_c = {1'b0, cur_q} - {1'b0, inc_q};
    if (inc_q == '0) begin
      next_c = stop_q;
    end else if (!down_q) begin
      next_c = (sum_c >= {1'b0, stop_q}) ? stop_q : sum_c[PW-1:0];
    end else begin
      next_c = (diff_c[PW] || (diff_c[PW-1:0] <= stop_q)) ? stop_q : diff_c[PW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      cnt_q    <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      inc_q    <= '0;
      reload_q <= '0;
      rpt_q    <= 1'b0;
      down_q   <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      inc_q    <= inc_d;
      reload_q <= reload_d;
      rpt_q    <= rpt_d;
      down_q   <= down_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  // Next-state and registered-output logic; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    stop_d   = stop_q;
    inc_d    = inc_q;
    reload_d = reload_q;
    rpt_d    = rpt_q;
    down_d   = down_q;
    busy_d   = busy_q;
    step_d   = 1'b0;
    done_d   = 1'b0;

    if (bus.abort_i) begin
      state_d = IDLE;
      cur_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            start_d  = bus.f_start_i;
            stop_d   = bus.f_stop_i;
            inc_d    = bus.f_step_i;
            reload_d = dwell_rl_c;
            rpt_d    = bus.repeat_i;
            down_d   = (bus.f_stop_i < bus.f_start_i);
            cur_d    = bus.f_start_i;
            cnt_d    = dwell_rl_c;
            step_d   = 1'b1;
            busy_d   = 1'b1;
            state_d  = SWEEP;
          end
        end
        SWEEP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else if (cur_q != stop_q) begin
            cur_d  = next_c;
            cnt_d  = reload_q;
            step_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (rpt_q) begin
              cur_d  = start_q;
              cnt_d  = reload_q;
              step_d = 1'b1;
            end else begin
              cur_d   = '0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl with hand-computed sweep points.
module tb_dds_sweep_ctrl;
  logic clk;
  logic arstn;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_pts[8];

  dds_sweep_ctrl_if #(.PHASE_WIDTH(16), .DWELL_WIDTH(16)) bus ();

  dds_sweep_ctrl #(.PHASE_WIDTH(16), .DWELL_WIDTH(16)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a single sweep and follow it cycle by cycle through done.
  task automatic run_sweep(input string nm, input logic [15:0] s, input logic [15:0] e,
                           input logic [15:0] st, input logic [15:0] dw,
                           input int d, input int n);
    bus.f_start_i = s;
    bus.f_stop_i  = e;
    bus.f_step_i  = st;
    bus.dwell_i   = dw;
    bus.repeat_i  = 1'b0;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < d; c++) begin
        chk({nm, "_phase"}, bus.phase_inc_o, exp_pts[p]);
        chk({nm, "_step"}, 16'(bus.step_o), 16'(c == 0));
        chk({nm, "_busy"}, 16'(bus.busy_o), 16'd1);
        chk({nm, "_done_early"}, 16'(bus.done_o), 16'd0);
        tick();
      end
    end
    chk({nm, "_done"}, 16'(bus.done_o), 16'd1);
    chk({nm, "_end_phase"}, bus.phase_inc_o, 16'h0000);
    chk({nm, "_end_busy"}, 16'(bus.busy_o), 16'd0);
    chk({nm, "_end_step"}, 16'(bus.step_o), 16'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    arstn = 1'b0;
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    bus.repeat_i  = 1'b0;
    bus.f_start_i = '0;
    bus.f_stop_i  = '0;
    bus.f_step_i  = '0;
    bus.dwell_i   = '0;
    #1;
    chk("rst_phase", bus.phase_inc_o, 16'h0000);
    chk("rst_busy", 16'(bus.busy_o), 16'd0);
    chk("rst_step", 16'(bus.step_o), 16'd0);
    chk("rst_done", 16'(bus.done_o), 16'd0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    tick();
    chk("idle_busy", 16'(bus.busy_o), 16'd0);

    exp_pts[0] = 16'h0100; exp_pts[1] = 16'h0200; exp_pts[2] = 16'h0300; exp_pts[3] = 16'h0400;
    run_sweep("up", 16'h0100, 16'h0400, 16'h0100, 16'd3, 3, 4);

    // Back-to-back: each start issued in the first busy-low cycle.
    exp_pts[0] = 16'h0100; exp_pts[1] = 16'h0280; exp_pts[2] = 16'h0400;
    run_sweep("clamp_up", 16'h0100, 16'h0400, 16'h0180, 16'd1, 1, 3);

    exp_pts[0] = 16'h0400; exp_pts[1] = 16'h0280; exp_pts[2] = 16'h0100;
    run_sweep("down", 16'h0400, 16'h0100, 16'h0180, 16'd1, 1, 3);

    exp_pts[0] = 16'hFF00; exp_pts[1] = 16'hFFFF;
    run_sweep("ovf", 16'hFF00, 16'hFFFF, 16'h0200, 16'd2, 2, 2);

    exp_pts[0] = 16'h0100; exp_pts[1] = 16'h0200; exp_pts[2] = 16'h0300;
    run_sweep("dwell0", 16'h0100, 16'h0300, 16'h0100, 16'd0, 1, 3);

    exp_pts[0] = 16'h0500; exp_pts[1] = 16'h0200;
    run_sweep("step0", 16'h0500, 16'h0200, 16'h0000, 16'd2, 2, 2);

    exp_pts[0] = 16'h1234;
    run_sweep("point", 16'h1234, 16'h1234, 16'h0040, 16'd5, 5, 1);
    tick();
    chk("point_done_clr", 16'(bus.done_o), 16'd0);

    // Repeat mode: two full passes, then a third wrap, with mid-sweep input changes.
    exp_pts[0] = 16'h0010; exp_pts[1] = 16'h0020; exp_pts[2] = 16'h0030;
    bus.f_start_i = 16'h0010;
    bus.f_stop_i  = 16'h0030;
    bus.f_step_i  = 16'h0010;
    bus.dwell_i   = 16'd2;
    bus.repeat_i  = 1'b1;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        for (int c = 0; c < 2; c++) begin
          chk("rpt_phase", bus.phase_inc_o, exp_pts[p]);
          chk("rpt_step", 16'(bus.step_o), 16'(c == 0));
          chk("rpt_done", 16'(bus.done_o), 16'(r > 0 && p == 0 && c == 0));
          chk("rpt_busy", 16'(bus.busy_o), 16'd1);
          bus.start_i = (r == 0 && p == 1 && c == 0);
          if (r == 0 && p == 1 && c == 0) begin
            bus.f_start_i = 16'h0999;
            bus.f_stop_i  = 16'h0001;
            bus.repeat_i  = 1'b0;
          end
          tick();
        end
      end
    end
    bus.start_i = 1'b0;
    chk("rpt_wrap_phase", bus.phase_inc_o, 16'h0010);
    chk("rpt_wrap_step", 16'(bus.step_o), 16'd1);
    chk("rpt_wrap_done", 16'(bus.done_o), 16'd1);

    // Abort mid-dwell of the repeating sweep.
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_phase", bus.phase_inc_o, 16'h0000);
    chk("abort_busy", 16'(bus.busy_o), 16'd0);
    chk("abort_done", 16'(bus.done_o), 16'd0);
    chk("abort_step", 16'(bus.step_o), 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_quiet_done", 16'(bus.done_o), 16'd0);
      chk("abort_quiet_busy", 16'(bus.busy_o), 16'd0);
    end

    // Abort together with start while idle.
    bus.f_start_i = 16'h0100;
    bus.f_stop_i  = 16'h0400;
    bus.f_step_i  = 16'h0100;
    bus.dwell_i   = 16'd3;
    bus.repeat_i  = 1'b0;
    bus.start_i   = 1'b1;
    bus.abort_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    chk("abst_busy", 16'(bus.busy_o), 16'd0);
    chk("abst_step", 16'(bus.step_o), 16'd0);
    chk("abst_phase", bus.phase_inc_o, 16'h0000);
    tick();
    chk("abst_busy2", 16'(bus.busy_o), 16'd0);

    // Asynchronous reset between clock edges mid-sweep.
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("prerst_step", 16'(bus.step_o), 16'd1);
    chk("prerst_phase", bus.phase_inc_o, 16'h0100);
    #2;
    arstn = 1'b0;
    #1;
    chk("arst_phase", bus.phase_inc_o, 16'h0000);
    chk("arst_busy", 16'(bus.busy_o), 16'd0);
    chk("arst_step", 16'(bus.step_o), 16'd0);
    chk("arst_done", 16'(bus.done_o), 16'd0);
    @(negedge clk);
    arstn = 1'b1;
    tick();
    chk("postrst_busy", 16'(bus.busy_o), 16'd0);
    chk("postrst_phase", bus.phase_inc_o, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
